// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and arithmetic helpers for the LIF neuron array
package lif_pkg;

    localparam int NUM_IN_DEF         = 3;
    localparam int IN_W_DEF           = 4;
    localparam int STATE_W_DEF        = 8;
    localparam int LEAK_SHIFT_DEF     = 3;
    localparam int THRESH_DEFAULT_DEF = 64;
    localparam int REFRAC_CYC_DEF     = 2;
    localparam int OUT_WEIGHT_DEF     = 16;
    localparam int COUNT_W_DEF        = 8;

    // Add with one guard bit and clamp to max_val; callers pass operands
    // zero-extended to 32 bits, so widths up to 32 are supported.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_val}) return max_val;
        return s[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) cnt = cnt + {31'b0, v[i]};
        return cnt;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - one leaky integrate-and-fire neuron
// Ports: clk, reset (sync, active-high), i_in (input current), i_thr (firing
// threshold), o_spike (registered one-cycle spike), o_state (membrane potential).
// Optional refractory hold selected by macro LIF_REFRACTORY_EN.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int IN_W_EFF   = IN_W_DEF,
    parameter int STATE_W    = STATE_W_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC_CYC = REFRAC_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_W_EFF-1:0] i_in,
    input  logic [STATE_W-1:0]  i_thr,
    output logic                o_spike,
    output logic [STATE_W-1:0]  o_state
);

    localparam logic [31:0] SAT_MAX = 32'((64'(1) << STATE_W) - 64'(1));

    logic [STATE_W-1:0] r_state;
    logic               r_spike;
    logic [STATE_W-1:0] w_leaked;
    logic [STATE_W-1:0] w_sum;
    logic               w_fire;

    assign w_leaked = r_state - (r_state >> LEAK_SHIFT);
    assign w_sum    = STATE_W'(sat_add(32'(w_leaked), 32'(i_in), SAT_MAX));
    // Unsigned compare: a zero threshold fires on every active cycle.
    assign w_fire   = (w_sum >= i_thr);

`ifdef LIF_REFRACTORY_EN
    // Width stays at least 1 so REFRAC_CYC=0 still elaborates; the counter
    // then only ever loads zero and the neuron never holds.
    localparam int RC_W = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_CYC);

    logic [RC_W-1:0] r_refrac;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= '0;
            r_spike  <= 1'b0;
            r_refrac <= '0;
        end else if (r_refrac != '0) begin
            r_state  <= '0;
            r_spike  <= 1'b0;
            r_refrac <= r_refrac - 1'b1;
        end else if (w_fire) begin
            r_state  <= '0;
            r_spike  <= 1'b1;
            r_refrac <= RC_LOAD;
        end else begin
            r_state  <= w_sum;
            r_spike  <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
            r_spike <= 1'b0;
        end else if (w_fire) begin
            r_state <= '0;
            r_spike <= 1'b1;
        end else begin
            r_state <= w_sum;
            r_spike <= 1'b0;
        end
    end
`endif

    assign o_spike = r_spike;
    assign o_state = r_state;

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - NUM_IN input LIF neurons feeding one weighted output neuron
// Ports: clk, reset (sync, active-high), in_vec (packed input currents),
// thr_we/thr_in (shared threshold load), spikes (input-neuron spikes),
// spike_out/out_state (output neuron), spike_count (wrapping spike_out count).
// Macro LIF_REFRACTORY_EN enables per-neuron refractory hold.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int NUM_IN         = NUM_IN_DEF,
    parameter int IN_W           = IN_W_DEF,
    parameter int STATE_W        = STATE_W_DEF,
    parameter int LEAK_SHIFT     = LEAK_SHIFT_DEF,
    parameter int THRESH_DEFAULT = THRESH_DEFAULT_DEF,
    parameter int REFRAC_CYC     = REFRAC_CYC_DEF,
    parameter int OUT_WEIGHT     = OUT_WEIGHT_DEF,
    parameter int COUNT_W        = COUNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IN*IN_W-1:0] in_vec,
    input  logic                   thr_we,
    input  logic [STATE_W-1:0]     thr_in,
    output logic [NUM_IN-1:0]      spikes,
    output logic                   spike_out,
    output logic [STATE_W-1:0]     out_state,
    output logic [COUNT_W-1:0]     spike_count
);

    // Wide enough for popcount * weight before clamping to the state range.
    localparam int W_W = STATE_W + $clog2(NUM_IN + 1);
    localparam logic [W_W-1:0] W_MAX = W_W'({STATE_W{1'b1}});

    logic [STATE_W-1:0] r_thr;
    logic [COUNT_W-1:0] r_count;
    logic [W_W-1:0]     w_weighted;
    logic [STATE_W-1:0] w_out_in;

    always_ff @(posedge clk) begin
        if (reset) r_thr <= STATE_W'(THRESH_DEFAULT);
        else if (thr_we) r_thr <= thr_in;
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        lif_neuron #(
            .IN_W_EFF   (IN_W),
            .STATE_W    (STATE_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC_CYC (REFRAC_CYC)
        ) u_neuron (
            .clk     (clk),
            .reset   (reset),
            .i_in    (in_vec[i*IN_W +: IN_W]),
            .i_thr   (r_thr),
            .o_spike (spikes[i]),
            .o_state ()
        );
    end

    assign w_weighted = W_W'(popcount(32'(spikes))) * W_W'(OUT_WEIGHT);
    assign w_out_in   = (w_weighted > W_MAX) ? {STATE_W{1'b1}} : w_weighted[STATE_W-1:0];

    lif_neuron #(
        .IN_W_EFF   (STATE_W),
        .STATE_W    (STATE_W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC_CYC (REFRAC_CYC)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .i_in    (w_out_in),
        .i_thr   (r_thr),
        .o_spike (spike_out),
        .o_state (out_state)
    );

    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else if (spike_out) r_count <= r_count + 1'b1;
    end

    assign spike_count = r_count;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed self-checking bench for lif_neuron_array
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] in_vec = 12'h000;
    logic        thr_we = 1'b0;
    logic [7:0]  thr_in = 8'h00;
    logic [2:0]  spikes;
    logic        spike_out;
    logic [7:0]  out_state;
    logic [7:0]  spike_count;

    int n_pass = 0;
    int n_total = 0;

    lif_neuron_array dut (
        .clk         (clk),
        .reset       (reset),
        .in_vec      (in_vec),
        .thr_we      (thr_we),
        .thr_in      (thr_in),
        .spikes      (spikes),
        .spike_out   (spike_out),
        .out_state   (out_state),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; thr_we = 1'b0; thr_in = 8'h00; in_vec = 12'h000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_vec = 12'hFFF;
        for (int k = 0; k < 3; k++) tick();
        n_total++; if (spikes !== 3'b000) $display("FAIL reset_spikes got %b want 000", spikes); else n_pass++;
        n_total++; if (spike_out !== 1'b0) $display("FAIL reset_spike_out got %b want 0", spike_out); else n_pass++;
        n_total++; if (out_state !== 8'd0) $display("FAIL reset_out_state got %0d want 0", out_state); else n_pass++;
        n_total++; if (spike_count !== 8'd0) $display("FAIL reset_count got %0d want 0", spike_count); else n_pass++;
        n_total++; if (dut.r_thr !== 8'd64) $display("FAIL reset_thr got %0d want 64", dut.r_thr); else n_pass++;
        reset = 1'b0; in_vec = 12'h000;
        for (int k = 0; k < 3; k++) tick();
        n_total++; if (dut.g_in[0].u_neuron.r_state !== 8'd0) $display("FAIL idle_state got %0d want 0", dut.g_in[0].u_neuron.r_state); else n_pass++;
        n_total++; if (out_state !== 8'd0) $display("FAIL idle_out_state got %0d want 0", out_state); else n_pass++;
    endtask

    task automatic test_integrate();
`ifdef LIF_REFRACTORY_EN
        int st_tab[9] = '{15, 29, 41, 51, 60, 0, 0, 0, 15};
`else
        int st_tab[9] = '{15, 29, 41, 51, 60, 0, 15, 29, 41};
`endif
        logic [2:0] exp_spk;
        do_reset();
        in_vec = 12'h00F;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_spk = (k == 5) ? 3'b001 : 3'b000;
            n_total++;
            if (dut.g_in[0].u_neuron.r_state !== 8'(st_tab[k]))
                $display("FAIL integ_state[%0d] got %0d want %0d", k, dut.g_in[0].u_neuron.r_state, st_tab[k]);
            else n_pass++;
            n_total++;
            if (spikes !== exp_spk) $display("FAIL integ_spikes[%0d] got %b want %b", k, spikes, exp_spk);
            else n_pass++;
            if (k == 6) begin
                n_total++; if (out_state !== 8'd16) $display("FAIL integ_out16 got %0d want 16", out_state); else n_pass++;
            end
            if (k == 7) begin
                n_total++; if (out_state !== 8'd14) $display("FAIL integ_out_leak got %0d want 14", out_state); else n_pass++;
            end
        end
    endtask

    task automatic test_thr_zero();
`ifdef LIF_REFRACTORY_EN
        logic [2:0] spk_tab[7] = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
        logic       so_tab[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_cnt = 8'd2;
`else
        logic [2:0] spk_tab[7] = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        logic       so_tab[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_cnt = 8'd5;
`endif
        do_reset();
        in_vec = 12'h111; thr_we = 1'b1; thr_in = 8'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
            thr_we = 1'b0;
            if (k == 0) begin
                n_total++; if (dut.r_thr !== 8'd0) $display("FAIL thr_load got %0d want 0", dut.r_thr); else n_pass++;
                n_total++; if (dut.g_in[1].u_neuron.r_state !== 8'd1) $display("FAIL thr_old_used got %0d want 1", dut.g_in[1].u_neuron.r_state); else n_pass++;
            end
            n_total++;
            if (spikes !== spk_tab[k]) $display("FAIL thr0_spikes[%0d] got %b want %b", k, spikes, spk_tab[k]);
            else n_pass++;
            n_total++;
            if (spike_out !== so_tab[k]) $display("FAIL thr0_spike_out[%0d] got %b want %b", k, spike_out, so_tab[k]);
            else n_pass++;
        end
        n_total++; if (spike_count !== exp_cnt) $display("FAIL thr0_count got %0d want %0d", spike_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_joint();
        do_reset();
        in_vec = 12'hFFF;
        for (int k = 0; k < 5; k++) tick();
        n_total++; if (spikes !== 3'b000) $display("FAIL joint_pre got %b want 000", spikes); else n_pass++;
        tick();
        n_total++; if (spikes !== 3'b111) $display("FAIL joint_spikes got %b want 111", spikes); else n_pass++;
        tick();
        n_total++; if (out_state !== 8'd48) $display("FAIL joint_out_state got %0d want 48", out_state); else n_pass++;
        n_total++; if (spike_out !== 1'b0) $display("FAIL joint_spike_out got %b want 0", spike_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_vec = 12'h00F;
        for (int k = 0; k < 5; k++) tick();
        n_total++; if (dut.g_in[0].u_neuron.r_state !== 8'd60) $display("FAIL mid_pre_state got %0d want 60", dut.g_in[0].u_neuron.r_state); else n_pass++;
        reset = 1'b1; thr_we = 1'b1; thr_in = 8'd5;
        tick();
        reset = 1'b0; thr_we = 1'b0;
        n_total++; if (spikes !== 3'b000) $display("FAIL mid_no_spike got %b want 000", spikes); else n_pass++;
        n_total++; if (dut.g_in[0].u_neuron.r_state !== 8'd0) $display("FAIL mid_state got %0d want 0", dut.g_in[0].u_neuron.r_state); else n_pass++;
        n_total++; if (dut.r_thr !== 8'd64) $display("FAIL mid_thr_prio got %0d want 64", dut.r_thr); else n_pass++;
        tick();
        n_total++; if (dut.g_in[0].u_neuron.r_state !== 8'd15) $display("FAIL mid_restart got %0d want 15", dut.g_in[0].u_neuron.r_state); else n_pass++;
        n_total++; if (spike_count !== 8'd0) $display("FAIL mid_count got %0d want 0", spike_count); else n_pass++;
    endtask

    task automatic test_wrap();
`ifdef LIF_REFRACTORY_EN
        int last = 767;
`else
        int last = 257;
`endif
        do_reset();
        in_vec = 12'h000; thr_we = 1'b1; thr_in = 8'd0;
        tick();
        thr_we = 1'b0;
        for (int k = 2; k <= last; k++) tick();
        n_total++; if (spike_out !== 1'b1) $display("FAIL wrap_last_pulse got %b want 1", spike_out); else n_pass++;
        n_total++; if (spike_count !== 8'd255) $display("FAIL wrap_pre got %0d want 255", spike_count); else n_pass++;
        tick();
        n_total++; if (spike_count !== 8'd0) $display("FAIL wrap_zero got %0d want 0", spike_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_thr_zero();
        test_joint();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
